// File: rtl/twiddle_addr_seq.sv
// Twiddle BROM read sequencer.
// Walks the NTT, INTT or pointwise region of the 4-lane twiddle ROM stage by
// stage. It drives the registered read address, and it drives a
// valid/stage/index tag that is delayed so that it lines up with the ROM
// data word.
module twiddle_addr_seq #(
    parameter int STAGE_GAP = 4,   // idle cycles between stages (PE drain), 0 allowed
    parameter int ROM_LAT   = 1    // BROM read latency, raddr_en -> tw_valid delay (>= 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       hold,
    output logic [7:0] raddr,
    output logic       raddr_en,
    output logic       tw_valid,
    output logic [2:0] tw_stage,
    output logic [4:0] tw_idx,
    output logic       tw_last,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] MODE_NTT  = 2'd0;
    localparam logic [1:0] MODE_INTT = 2'd1;
    localparam logic [1:0] MODE_PWM  = 2'd2;
    localparam logic [1:0] MODE_BAD  = 2'd3;

    // Gap counter wide enough for 0..STAGE_GAP-1; one bit minimum so the
    // STAGE_GAP=0 build still has a legal (unused) register.
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FLUSH
    } state_t;

    // Address map of the three ROM regions; results never exceed 221.
    //   NTT  s<=5: (2^s-1) + (c >> (5-s)),   s=6: 63 + c
    //   INTT s=0 : 95 + c,   s>=1: (191 - 2^(7-s)) + (c >> (s-1))
    //   PWM      : 190 + c
    function automatic logic [7:0] addr_map(input logic [1:0] m,
                                            input logic [2:0] s,
                                            input logic [4:0] c);
        logic [8:0] base;
        logic [4:0] off;
        logic [8:0] sum;
        base = 9'd0;
        off  = c;
        case (m)
            MODE_NTT: begin
                if (s == 3'd6) begin
                    base = 9'd63;
                    off  = c;
                end else begin
                    base = (9'd1 << s) - 9'd1;
                    off  = c >> (3'd5 - s);
                end
            end
            MODE_INTT: begin
                if (s == 3'd0) begin
                    base = 9'd95;
                    off  = c;
                end else begin
                    base = 9'd191 - (9'd1 << (3'd7 - s));
                    off  = c >> (s - 3'd1);
                end
            end
            default: begin
                base = 9'd190;
                off  = c;
            end
        endcase
        sum = base + {4'd0, off};
        return sum[7:0];
    endfunction

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [2:0]        r_stage;
    logic [4:0]        r_idx;
    logic [GW-1:0]     r_gap;
    logic              r_busy;
    logic              r_done;

    // Read port registers plus the tag that belongs to the read just issued
    logic [7:0]        r_raddr;
    logic              r_rd_en;
    logic [2:0]        r_rd_stage;
    logic [4:0]        r_rd_idx;
    logic              r_rd_last;

    // Tag delay line matching the ROM latency; the last entry faces ROM dout
    logic [ROM_LAT-1:0]       r_pv;
    logic [ROM_LAT-1:0][2:0]  r_ps;
    logic [ROM_LAT-1:0][4:0]  r_pi;
    logic [ROM_LAT-1:0]       r_pl;

    logic [2:0]        w_last_stage;
    logic              w_stage_end;
    logic              w_op_end;
    logic [7:0]        w_addr;
    logic              w_mode_ok;
    logic              w_tw_last;

    assign w_last_stage = (r_mode == MODE_PWM) ? 3'd0 : 3'd6;
    assign w_stage_end  = (r_idx == 5'd31);
    assign w_op_end     = w_stage_end && (r_stage == w_last_stage);
    assign w_addr       = addr_map(r_mode, r_stage, r_idx);
    assign w_mode_ok    = (mode != MODE_BAD);
    assign w_tw_last    = r_pl[ROM_LAT-1];

    // Sequencer FSM: counters, read issue, stage gaps and completion handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_NTT;
            r_stage    <= 3'd0;
            r_idx      <= 5'd0;
            r_gap      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_raddr    <= 8'd0;
            r_rd_en    <= 1'b0;
            r_rd_stage <= 3'd0;
            r_rd_idx   <= 5'd0;
            r_rd_last  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_mode_ok) begin
                        r_mode  <= mode;
                        r_stage <= 3'd0;
                        r_idx   <= 5'd0;
                        r_gap   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A held cycle issues nothing; raddr and counters stay put
                    if (!hold) begin
                        r_raddr    <= w_addr;
                        r_rd_en    <= 1'b1;
                        r_rd_stage <= r_stage;
                        r_rd_idx   <= r_idx;
                        r_rd_last  <= w_op_end;
                        if (w_op_end) begin
                            r_idx   <= 5'd0;
                            r_state <= S_FLUSH;
                        end else if (w_stage_end) begin
                            r_stage <= r_stage + 3'd1;
                            r_idx   <= 5'd0;
                            r_gap   <= '0;
                            if (STAGE_GAP > 0) begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (!hold) begin
                        if (r_gap == GAP_LAST) begin
                            r_gap   <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_gap <= r_gap + GW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Finish once the final twiddle has been presented on dout
                    if (w_tw_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay the read tag by ROM_LAT cycles so it accompanies the ROM data word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv <= '0;
            r_ps <= '0;
            r_pi <= '0;
            r_pl <= '0;
        end else begin
            r_pv[0] <= r_rd_en;
            r_ps[0] <= r_rd_stage;
            r_pi[0] <= r_rd_idx;
            r_pl[0] <= r_rd_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
                r_pi[i] <= r_pi[i-1];
                r_pl[i] <= r_pl[i-1];
            end
        end
    end

    assign raddr    = r_raddr;
    assign raddr_en = r_rd_en;
    assign tw_valid = r_pv[ROM_LAT-1];
    assign tw_stage = r_ps[ROM_LAT-1];
    assign tw_idx   = r_pi[ROM_LAT-1];
    assign tw_last  = w_tw_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Bench for twiddle_addr_seq: scoreboard of expected reads/twiddles plus
// per-scenario timing checks. u_dut uses STAGE_GAP=4, u_dut0 uses STAGE_GAP=0.
module tb_twiddle_addr_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start0;
    logic [1:0] mode, mode0;
    logic       hold, hold0;

    logic [7:0] raddr, raddr0;
    logic       raddr_en, raddr_en0;
    logic       tw_valid, tw_valid0;
    logic [2:0] tw_stage, tw_stage0;
    logic [4:0] tw_idx, tw_idx0;
    logic       tw_last, tw_last0;
    logic       busy, busy0;
    logic       done, done0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] stage;
        logic [4:0] idx;
        logic       last;
    } rd_t;

    rd_t q_rd[$];
    rd_t q_tw[$];
    rd_t m_r, m_t;

    always #5 clk = ~clk;

    twiddle_addr_seq #(.STAGE_GAP(4), .ROM_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .hold(hold),
        .raddr(raddr), .raddr_en(raddr_en), .tw_valid(tw_valid),
        .tw_stage(tw_stage), .tw_idx(tw_idx), .tw_last(tw_last),
        .busy(busy), .done(done)
    );

    twiddle_addr_seq #(.STAGE_GAP(0), .ROM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0), .hold(hold0),
        .raddr(raddr0), .raddr_en(raddr_en0), .tw_valid(tw_valid0),
        .tw_stage(tw_stage0), .tw_idx(tw_idx0), .tw_last(tw_last0),
        .busy(busy0), .done(done0)
    );

    // Reference address map written from the region table
    function automatic logic [7:0] f_model(input int m, input int s, input int c);
        int a;
        if (m == 2)      a = 190 + c;
        else if (m == 0) a = (s == 6) ? 63 + c : ((1 << s) - 1) + c / (32 >> s);
        else             a = (s == 0) ? 95 + c : (191 - (128 >> s)) + c / (1 << (s - 1));
        return a[7:0];
    endfunction

    task automatic push_op(input int m);
        rd_t e;
        int nst;
        nst = (m == 2) ? 1 : 7;
        for (int s = 0; s < nst; s++) begin
            for (int c = 0; c < 32; c++) begin
                e.addr  = f_model(m, s, c);
                e.stage = 3'(s);
                e.idx   = 5'(c);
                e.last  = (s == nst - 1) && (c == 31);
                q_rd.push_back(e);
                q_tw.push_back(e);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard monitor on u_dut: every read and every twiddle is popped and compared
    always @(posedge clk) begin
        #1;
        if (raddr_en === 1'b1) begin
            n_vec++;
            if (q_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected actual raddr=%0d required=no read", raddr);
            end else begin
                m_r = q_rd.pop_front();
                if (raddr !== m_r.addr) begin
                    n_err++;
                    $display("FAIL rd_addr actual=%0d required=%0d (stage %0d idx %0d)",
                             raddr, m_r.addr, m_r.stage, m_r.idx);
                end
            end
        end
        if (tw_valid === 1'b1) begin
            n_vec++;
            if (q_tw.size() == 0) begin
                n_err++;
                $display("FAIL tw_unexpected actual stage=%0d idx=%0d required=no twiddle",
                         tw_stage, tw_idx);
            end else begin
                m_t = q_tw.pop_front();
                if ({tw_stage, tw_idx, tw_last} !== {m_t.stage, m_t.idx, m_t.last}) begin
                    n_err++;
                    $display("FAIL tw_tag actual s=%0d i=%0d l=%0d required s=%0d i=%0d l=%0d",
                             tw_stage, tw_idx, tw_last, m_t.stage, m_t.idx, m_t.last);
                end
            end
        end else if (tw_last !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL tw_last_no_valid actual=%0b required=0", tw_last);
        end
    end

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = 2'd0; hold = 1'b0;
        start0 = 1'b0; mode0 = 2'd0; hold0 = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({raddr, raddr_en, tw_valid, tw_stage, tw_idx, tw_last, busy, done} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {raddr, raddr_en, tw_valid, tw_stage, tw_idx, tw_last, busy, done});
        end
        n_vec++;
        if ({raddr0, raddr_en0, tw_valid0, busy0, done0} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_outputs_gap0 actual=%h required=0",
                     {raddr0, raddr_en0, tw_valid0, busy0, done0});
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({busy, raddr_en, done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset actual=%b required=000", {busy, raddr_en, done});
        end
    endtask

    task automatic test_ntt;
        int reads, tws, gaps, badgap, run, last_cyc, done_cyc;
        bit seen;
        push_op(0);
        pulse_start(2'd0);
        n_vec++;
        if ({busy, raddr_en} !== 2'b10) begin
            n_err++;
            $display("FAIL ntt_busy_rise actual busy/en=%b required=10", {busy, raddr_en});
        end
        reads = 0; tws = 0; gaps = 0; badgap = 0; run = 0; last_cyc = -1; done_cyc = -1; seen = 0;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en) begin
                reads++;
                if (seen && run != 0) begin
                    gaps++;
                    if (run != 4) badgap++;
                end
                seen = 1;
                run = 0;
            end else if (seen) begin
                run++;
            end
            if (tw_valid) tws++;
            if (tw_last) last_cyc = cyc;
            if (done) done_cyc = cyc;
        end
        n_vec++;
        if (reads != 224 || tws != 224) begin
            n_err++;
            $display("FAIL ntt_counts actual reads=%0d tw=%0d required 224/224", reads, tws);
        end
        n_vec++;
        if (gaps != 6 || badgap != 0) begin
            n_err++;
            $display("FAIL ntt_stage_gaps actual gaps=%0d bad=%0d required 6/0", gaps, badgap);
        end
        n_vec++;
        if (done_cyc != 250 || last_cyc != 249) begin
            n_err++;
            $display("FAIL ntt_done_timing actual done=%0d last=%0d required 250/249", done_cyc, last_cyc);
        end
        n_vec++;
        if (busy !== 1'b0 || q_rd.size() != 0 || q_tw.size() != 0) begin
            n_err++;
            $display("FAIL ntt_end_state actual busy=%b qrd=%0d qtw=%0d required 0/0/0",
                     busy, q_rd.size(), q_tw.size());
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL ntt_done_pulse actual=%b required=0", done);
        end
    endtask

    task automatic test_intt_restart_ignored;
        int reads, done_cyc;
        push_op(1);
        pulse_start(2'd1);
        reads = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en) reads++;
            if (done) done_cyc = cyc;
            start = (cyc == 40);
            mode  = (cyc == 40) ? 2'd2 : 2'd1;
        end
        start = 1'b0;
        n_vec++;
        if (reads != 224 || done_cyc != 250) begin
            n_err++;
            $display("FAIL intt_run actual reads=%0d done=%0d required 224/250", reads, done_cyc);
        end
        n_vec++;
        if (q_rd.size() != 0 || q_tw.size() != 0) begin
            n_err++;
            $display("FAIL intt_scoreboard_left actual qrd=%0d qtw=%0d required 0/0",
                     q_rd.size(), q_tw.size());
        end
    endtask

    task automatic test_pwm;
        int reads, first_en, last_en, first_tw, done_cyc;
        push_op(2);
        pulse_start(2'd2);
        reads = 0; first_en = -1; last_en = -1; first_tw = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en) begin
                reads++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (tw_valid && first_tw < 0) first_tw = cyc;
            if (done) done_cyc = cyc;
        end
        n_vec++;
        if (reads != 32 || first_en != 1 || last_en != 32) begin
            n_err++;
            $display("FAIL pwm_reads actual n=%0d first=%0d last=%0d required 32/1/32",
                     reads, first_en, last_en);
        end
        n_vec++;
        if (first_tw != 2 || done_cyc != 34) begin
            n_err++;
            $display("FAIL pwm_timing actual tw=%0d done=%0d required 2/34", first_tw, done_cyc);
        end
    endtask

    task automatic test_hold;
        int reads, done_cyc, hcyc, bad_hold;
        push_op(0);
        pulse_start(2'd0);
        reads = 0; done_cyc = -1; hcyc = -10; bad_hold = 0;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en) reads++;
            if (done) done_cyc = cyc;
            if (cyc >= hcyc + 1 && cyc <= hcyc + 3) begin
                if (raddr_en !== 1'b0 || raddr !== 8'd73) bad_hold++;
                if (cyc == hcyc + 3) hold = 1'b0;
            end
            if (cyc == hcyc + 4) begin
                n_vec++;
                if (raddr_en !== 1'b1 || raddr !== 8'd74) begin
                    n_err++;
                    $display("FAIL hold_resume actual en=%b raddr=%0d required 1/74", raddr_en, raddr);
                end
            end
            if (cyc >= hcyc + 2 && cyc <= hcyc + 5) begin
                n_vec++;
                if (tw_valid !== (cyc == hcyc + 5)) begin
                    n_err++;
                    $display("FAIL hold_tw_bubble actual tw_valid=%b required=%b at +%0d",
                             tw_valid, (cyc == hcyc + 5), cyc - hcyc);
                end
            end
            if (hcyc < 0 && raddr_en && raddr == 8'd73) begin
                hcyc = cyc;
                hold = 1'b1;
            end
        end
        hold = 1'b0;
        n_vec++;
        if (hcyc < 0 || bad_hold != 0) begin
            n_err++;
            $display("FAIL hold_freeze actual seen=%0d bad=%0d required 1/0", hcyc >= 0, bad_hold);
        end
        n_vec++;
        if (reads != 224 || done_cyc != 253) begin
            n_err++;
            $display("FAIL hold_totals actual reads=%0d done=%0d required 224/253", reads, done_cyc);
        end
    endtask

    task automatic test_illegal_mode;
        int bad;
        pulse_start(2'd3);
        bad = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (busy !== 1'b0 || raddr_en !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL illegal_mode actual active_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid_intt;
        int reads, bad, done_cyc;
        bit reached;
        push_op(1);
        pulse_start(2'd1);
        reads = 0; reached = 0;
        for (int cyc = 1; cyc <= 300 && !reached; cyc++) begin
            tick();
            if (raddr_en) reads++;
            if (reads == 3 * 32 + 5) reached = 1;
        end
        n_vec++;
        if (!reached) begin
            n_err++;
            $display("FAIL rst_mid_reach actual reads=%0d required 101", reads);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({raddr, raddr_en, tw_valid, tw_stage, tw_idx, tw_last, busy, done} !== 21'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs actual=%h required=0",
                     {raddr, raddr_en, tw_valid, tw_stage, tw_idx, tw_last, busy, done});
        end
        q_rd.delete();
        q_tw.delete();
        repeat (2) tick();
        reset = 1'b0;
        bad = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (busy !== 1'b0 || raddr_en !== 1'b0 || done !== 1'b0 || tw_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_mid_no_resume actual active_cycles=%0d required 0", bad);
        end
        push_op(2);
        pulse_start(2'd2);
        reads = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en) reads++;
            if (done) done_cyc = cyc;
        end
        n_vec++;
        if (reads != 32 || done_cyc != 34 || q_rd.size() != 0) begin
            n_err++;
            $display("FAIL rst_then_pwm actual reads=%0d done=%0d left=%0d required 32/34/0",
                     reads, done_cyc, q_rd.size());
        end
    endtask

    task automatic test_no_gap;
        int k, first_en, last_en, last_tw, done_cyc;
        start0 = 1'b1;
        mode0  = 2'd0;
        tick();
        start0 = 1'b0;
        k = 0; first_en = -1; last_en = -1; last_tw = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            tick();
            if (raddr_en0) begin
                n_vec++;
                if (raddr0 !== f_model(0, k / 32, k % 32)) begin
                    n_err++;
                    $display("FAIL gap0_addr actual=%0d required=%0d (read %0d)",
                             raddr0, f_model(0, k / 32, k % 32), k);
                end
                k++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (tw_last0) last_tw = cyc;
            if (done0) done_cyc = cyc;
        end
        n_vec++;
        if (k != 224 || first_en != 1 || last_en != 224) begin
            n_err++;
            $display("FAIL gap0_span actual n=%0d first=%0d last=%0d required 224/1/224",
                     k, first_en, last_en);
        end
        n_vec++;
        if (last_tw != 225 || done_cyc != 226) begin
            n_err++;
            $display("FAIL gap0_done actual last=%0d done=%0d required 225/226", last_tw, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_ntt();
        test_intt_restart_ignored();
        test_pwm();
        test_hold();
        test_illegal_mode();
        test_reset_mid_intt();
        test_no_gap();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
